// File: rtl/pipelined_shifter.sv
// Pipelined shift/rotate unit: SLL, SRL, SRA, ROL, ROR with carry-out and zero flags.
// The log2(WIDTH) barrel-shifter levels are split evenly over STAGES elastic
// register stages, each with its own valid bit and full backpressure.
module pipelined_shifter #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_amt,
    input  logic [2:0]               in_op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic                     out_carry,
    output logic                     out_zero
);

    localparam int unsigned L   = $clog2(WIDTH);
    localparam int unsigned LPS = L / STAGES;

    localparam logic [2:0] OP_SLL = 3'd0;
    localparam logic [2:0] OP_SRL = 3'd1;
    localparam logic [2:0] OP_SRA = 3'd2;
    localparam logic [2:0] OP_ROL = 3'd3;
    localparam logic [2:0] OP_ROR = 3'd4;

    // Applies LPS mux levels starting at level 'base'; returns {carry, data}.
    // The last bit moved out at each active level is the top (left ops) or
    // bottom (right ops) 2^k-bit chunk edge, which equals the overall carry.
    function automatic logic [WIDTH:0] shift_levels(
        input logic [WIDTH-1:0] d_in,
        input logic [LPS-1:0]   bits,
        input logic [2:0]       op,
        input logic             c_in,
        input int unsigned      base
    );
        logic [WIDTH-1:0] d;
        logic             c;
        int unsigned      sh;
        d = d_in;
        c = c_in;
        for (int unsigned j = 0; j < LPS; j++) begin
            sh = 32'd1 << (base + j);
            if (bits[j]) begin
                case (op)
                    OP_SLL: begin
                        c = d[L'(WIDTH - sh)];
                        d = d << sh;
                    end
                    OP_SRL: begin
                        c = d[L'(sh - 1)];
                        d = d >> sh;
                    end
                    OP_SRA: begin
                        c = d[L'(sh - 1)];
                        d = WIDTH'($signed(d) >>> sh);
                    end
                    OP_ROL: begin
                        c = d[L'(WIDTH - sh)];
                        d = (d << sh) | (d >> (WIDTH - sh));
                    end
                    OP_ROR: begin
                        c = d[L'(sh - 1)];
                        d = (d >> sh) | (d << (WIDTH - sh));
                    end
                    default: begin
                        c = c;
                        d = d;
                    end
                endcase
            end
        end
        return {c, d};
    endfunction

    logic [WIDTH-1:0]  st_data  [STAGES];
    logic [L-1:0]      st_rem   [STAGES];
    logic [L-1:0]      st_orig  [STAGES];
    logic [2:0]        st_op    [STAGES];
    logic              st_carry [STAGES];
    logic              st_valid [STAGES];
    logic [STAGES-1:0] valid_vec;
    logic [STAGES-1:0] accept;
    logic              zero_flag;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic [WIDTH-1:0] up_data;
        logic [L-1:0]     up_rem;
        logic [L-1:0]     up_orig;
        logic [2:0]       up_op;
        logic             up_carry;
        logic             up_valid;
        logic [WIDTH:0]   lv;

        if (s == 0) begin : g_first
            assign up_data  = in_data;
            assign up_rem   = in_amt;
            assign up_orig  = in_amt;
            assign up_op    = in_op;
            assign up_carry = 1'b0;
            assign up_valid = in_valid;
        end else begin : g_next
            assign up_data  = st_data[s-1];
            assign up_rem   = st_rem[s-1];
            assign up_orig  = st_orig[s-1];
            assign up_op    = st_op[s-1];
            assign up_carry = st_carry[s-1];
            assign up_valid = st_valid[s-1];
        end

        assign lv           = shift_levels(up_data, up_rem[LPS-1:0], up_op, up_carry, s * LPS);
        assign valid_vec[s] = st_valid[s];
        // A stage can load if it or any stage downstream of it has a bubble, or the sink drains.
        assign accept[s]    = out_ready || !(&valid_vec[STAGES-1:s]);

        // Stage register: loads whenever the stage can accept; payload only on a valid transfer.
        always_ff @(posedge clk) begin
            if (rst) begin
                st_valid[s] <= 1'b0;
                st_data[s]  <= '0;
                st_rem[s]   <= '0;
                st_orig[s]  <= '0;
                st_op[s]    <= '0;
                st_carry[s] <= 1'b0;
            end else if (accept[s]) begin
                st_valid[s] <= up_valid;
                if (up_valid) begin
                    st_data[s]  <= lv[WIDTH-1:0];
                    st_rem[s]   <= up_rem >> LPS;
                    st_orig[s]  <= up_orig;
                    st_op[s]    <= up_op;
                    st_carry[s] <= lv[WIDTH] & (up_orig != '0);
                end
            end
        end

        if (s == STAGES - 1) begin : g_last
            // Zero flag registered alongside the final data so both change together.
            always_ff @(posedge clk) begin
                if (rst) begin
                    zero_flag <= 1'b0;
                end else if (accept[s] && up_valid) begin
                    zero_flag <= (lv[WIDTH-1:0] == '0);
                end
            end
        end
    end

    assign in_ready   = accept[0];
    assign out_valid  = st_valid[STAGES-1];
    assign out_result = st_data[STAGES-1];
    assign out_carry  = st_carry[STAGES-1];
    assign out_zero   = zero_flag;

endmodule

// File: tb/tb_pipelined_shifter.sv
// Self-checking bench for pipelined_shifter: directed shots, backpressure,
// mid-flight reset and a randomized scoreboard regression.
module tb_pipelined_shifter;

    localparam int unsigned W = 16;
    localparam int unsigned S = 2;
    localparam int unsigned L = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [L-1:0] in_amt;
    logic [2:0]   in_op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_carry;
    logic         out_zero;

    int total = 0;
    int bad   = 0;
    int pops  = 0;

    logic         rnd_on      = 1'b0;
    logic         ready_force = 1'b1;

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
    } exp_t;

    exp_t sb[$];
    logic hold_pend = 1'b0;
    exp_t hold_val;

    pipelined_shifter #(.WIDTH(W), .STAGES(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_amt     (in_amt),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_carry  (out_carry),
        .out_zero   (out_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: whole-amount shift/rotate from the operation definitions.
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [L-1:0] amt);
        exp_t         e;
        int           n;
        logic [L-1:0] top;
        logic [L-1:0] low;
        n     = int'(amt);
        top   = L'(W - n);
        low   = L'(n - 1);
        e.res = a;
        e.c   = 1'b0;
        if (n != 0) begin
            case (op)
                3'd0: begin e.res = a << n;                       e.c = a[top];       end
                3'd1: begin e.res = a >> n;                       e.c = a[low];       end
                3'd2: begin e.res = W'($signed(a) >>> n);         e.c = a[low];       end
                3'd3: begin e.res = (a << n) | (a >> (W - n));    e.c = e.res[0];     end
                3'd4: begin e.res = (a >> n) | (a << (W - n));    e.c = e.res[W-1];   end
                default: begin e.res = a;                         e.c = 1'b0;         end
            endcase
        end
        return e;
    endfunction

    // Monitor: pushes expectations on accept, pops and compares on output transfer.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                chk("hold_valid", 64'(out_valid), 64'(1));
                chk("hold_data", 64'({out_result, out_carry}), 64'(hold_val));
            end
            hold_pend = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    pops++;
                    if (sb.size() == 0) begin
                        chk("unexpected_output", 64'(out_result), 64'hDEAD_0000_0000_0000);
                    end else begin
                        e = sb.pop_front();
                        chk("result", 64'(out_result), 64'(e.res));
                        chk("carry", 64'(out_carry), 64'(e.c));
                        chk("zero", 64'(out_zero), 64'(e.res == '0));
                    end
                end else begin
                    hold_pend = 1'b1;
                    hold_val  = '{res: out_result, c: out_carry};
                end
            end
            if (in_valid && in_ready) sb.push_back(model(in_op, in_data, in_amt));
        end
    end

    // Sole driver of out_ready; changes a little after the main stimulus each cycle.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = rnd_on ? ($urandom_range(3) != 0) : ready_force;
        end
    end

    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [L-1:0] amt);
        int n;
        in_valid = 1'b1;
        in_op    = op;
        in_data  = a;
        in_amt   = amt;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("send_timeout", 64'(n), 64'(0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic shot(input string name, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [L-1:0] amt, input logic [W-1:0] er, input logic ec);
        int cnt;
        send(op, a, amt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!out_valid && cnt < 20);
        chk({name, "_latency"}, 64'(cnt), 64'(S));
        chk({name, "_result"}, 64'(out_result), 64'(er));
        chk({name, "_carry"}, 64'(out_carry), 64'(ec));
        chk({name, "_zero"}, 64'(out_zero), 64'(er == '0));
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int limit);
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 64'(n >= limit), 64'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int acc;
        int cyc;
        int p0;
        rst      = 1'b1;
        in_valid = 1'b1;
        in_op    = 3'd0;
        in_data  = 16'h1234;
        in_amt   = 4'd3;

        // Reset held with a valid input pending.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_result", 64'(out_result), 64'(0));
        chk("rst_out_carry", 64'(out_carry), 64'(0));
        chk("rst_out_zero", 64'(out_zero), 64'(0));
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_release_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;

        // Per-op single shots.
        shot("sll", 3'd0, 16'h8421, 4'd5, 16'h8420, 1'b0);
        shot("srl", 3'd1, 16'h8421, 4'd5, 16'h0421, 1'b0);
        shot("sra", 3'd2, 16'h8421, 4'd5, 16'hFC21, 1'b0);
        shot("rol", 3'd3, 16'h8421, 4'd5, 16'h8430, 1'b0);
        shot("ror", 3'd4, 16'h8421, 4'd5, 16'h0C21, 1'b0);

        // Boundaries.
        shot("sra_max", 3'd2, 16'h8000, 4'd15, 16'hFFFF, 1'b0);
        shot("sll_max", 3'd0, 16'h0001, 4'd15, 16'h8000, 1'b0);
        shot("sll_out", 3'd0, 16'h8000, 4'd1, 16'h0000, 1'b1);
        shot("rol_c1", 3'd3, 16'h4000, 4'd2, 16'h0001, 1'b1);
        shot("ror_c1", 3'd4, 16'h0002, 4'd2, 16'h8000, 1'b1);
        for (int op = 0; op < 5; op++) shot("amt0", 3'(op), 16'hA5C3, 4'd0, 16'hA5C3, 1'b0);
        shot("reserved", 3'd6, 16'h8421, 4'd7, 16'h8421, 1'b0);

        // Backpressure: six ops against a stalled sink.
        ready_force = 1'b0;
        @(posedge clk);
        #1;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1;
            in_op    = 3'(acc % 5);
            in_data  = W'($urandom);
            in_amt   = L'(acc + 1);
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk);
            #1;
        end
        chk("bp_accepts", 64'(acc), 64'(S));
        chk("bp_in_ready_low", 64'(in_ready), 64'(0));
        chk("bp_out_valid_held", 64'(out_valid), 64'(1));
        p0 = pops;
        ready_force = 1'b1;
        cyc = 0;
        while (acc < 6 && cyc < 50) begin
            in_valid = 1'b1;
            in_op    = 3'(acc % 5);
            in_data  = W'($urandom);
            in_amt   = L'(acc + 1);
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        settle(50);
        chk("bp_pop_count", 64'(pops - p0), 64'(6));

        // Reset mid-flight: two in-flight ops must vanish.
        ready_force = 1'b0;
        @(posedge clk);
        #1;
        send(3'd0, 16'h00FF, 4'd4);
        send(3'd1, 16'hFF00, 4'd4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ready_force = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_in_ready", 64'(in_ready), 64'(1));
        repeat (4) @(posedge clk);
        #1;
        shot("post_rst", 3'd3, 16'h1234, 4'd4, 16'h2341, 1'b1);

        // Random regression with random sink stalls and input gaps.
        rnd_on = 1'b1;
        for (int i = 0; i < 400; i++) begin
            send(3'($urandom_range(7)), W'($urandom), L'($urandom_range(W - 1)));
            if ($urandom_range(3) == 0) begin
                repeat ($urandom_range(3)) @(posedge clk);
                #1;
            end
        end
        rnd_on = 1'b0;
        ready_force = 1'b1;
        settle(200);
        chk("final_scoreboard_empty", 64'(sb.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipelined_shifter.md
# pipelined_shifter

Parametrised, pipelined shift/rotate unit for the execute stage. Supports logical left, logical right, arithmetic right, rotate left and rotate right on a WIDTH-bit operand. The log2(WIDTH) mux levels are spread over STAGES register stages behind a valid/ready handshake, with full backpressure. It also produces carry-out (last bit shifted out) and zero flags for the flag logic.

## Interface
- WIDTH, 16: operand width; power of two, 8..64.
- STAGES, 2: pipeline register stages; must divide L = log2(WIDTH); 1..L.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  input operation valid.
- in_ready  output  1  unit can accept the input this cycle.
- in_data  input  WIDTH  operand A.
- in_amt  input  L  shift amount, 0..WIDTH-1.
- in_op  input  3  0=SLL, 1=SRL, 2=SRA, 3=ROL, 4=ROR; 5..7 reserved, treated as pass-through (result=A, carry=0).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_result  output  WIDTH  shifted/rotated operand.
- out_carry  output  1  last bit shifted/rotated out; 0 when amt=0.
- out_zero  output  1  out_result == 0.

## Operation
- Stage s (0..STAGES-1) applies amt bits [s*L/STAGES +: L/STAGES], LSB level first. Each level conditionally moves by 2^k, then the stage registers the partial result.
- Each stage register holds: partial data, remaining amt bits, op, original amt, and the carry candidate.
- Fill bits: SLL/SRL fill 0. SRA fills with A[WIDTH-1] at every level. ROL/ROR wrap.
- Carry (amt=n>0): SLL = A[WIDTH-n]; SRL/SRA = A[n-1]; ROL = result[0]; ROR = result[WIDTH-1].
- Carry is tracked per stage so no full-width datapath is re-evaluated at the output. out_zero is computed from the final stage data, combinationally or registered, provided it matches out_result on the same cycle.
- Elastic pipeline, each stage with its own valid bit:
  - Stage i loads when !valid[i] || advance[i+1].
  - The last stage advances when out_ready.
  - in_ready = !valid[0] || advance[1] (with STAGES=1, the last stage's own condition).
- in_ready may depend combinationally on out_ready. No combinational path from in_data/in_valid to any output.
- A transfer occurs only on valid && ready. Data held under backpressure must not change.
- Reset, including mid-operation: all valid bits to 0, in-flight operations discarded, out_valid=0, out_result=0, out_carry=0, out_zero=0. In the cycle after reset deasserts, in_ready=1.

## Timing
- Latency: an operation accepted at edge t presents out_valid=1 after edge t+STAGES, when there is no backpressure.
- Throughput: one operation per cycle while out_ready=1. No bubbles are inserted.
- out_ready=0 with the pipe full: in_ready=0 and all stages hold.
- out_ready=0 with bubbles: bubbles collapse, one per cycle, until the pipe is full.
- Simultaneous output consume and input accept with a full pipe: both occur in the same cycle and occupancy is unchanged.
- out_valid, once asserted, stays high with stable data until out_ready.
- amt=0 for every op: result=A, carry=0, latency unchanged.

## Test plan
- Reset: hold rst with in_valid=1 -> out_valid=0, outputs 0. Release -> in_ready=1.
- Per-op single shots (WIDTH=16, STAGES=2, A=0x8421, amt=5), each with out_valid exactly 2 cycles after accept:
  - SLL -> 0x8420, carry=0.
  - SRL -> 0x0421, carry=0.
  - SRA -> 0xFC21, carry=0.
  - ROL -> 0x8430, carry=0.
  - ROR -> 0x0C21, carry=0.
- Boundaries:
  - SRA 0x8000 by 15 -> 0xFFFF, carry=0.
  - SLL 0x0001 by 15 -> 0x8000.
  - SLL 0x8000 by 1 -> 0x0000, zero=1, carry=1.
  - Any op with amt=0 -> A, carry=0.
- Backpressure: stream 6 ops with out_ready=0 -> in_ready drops after 2 accepts (pipe full). Raise out_ready -> results emerge in order, one per cycle, none lost or duplicated.
- Reset mid-flight: accept 2 ops, then pulse rst -> neither result ever appears, and a new op after reset completes with correct latency.
- Random regression: all WIDTH in {8,16,32} and legal STAGES, random ops/amt/handshakes, checked against a reference model with a scoreboard.
